// File: rtl/dram_ctrl.sv
// dram_ctrl: single-beat request controller in front of the dram array model.
// Host reads/writes arrive over valid/ready; read data returns as a one-cycle
// rsp_valid pulse. Optional periodic row refresh is compiled in when the macro
// DRAM_CTRL_REFRESH_EN is defined; without it the controller never refreshes.
module dram_ctrl #(
  parameter int unsigned READ_LAT         = 1,
  parameter int unsigned REFRESH_INTERVAL = 64,
  parameter int unsigned ROW_BITS         = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [11:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        refresh_busy,
  output logic [11:0] mem_address,
  output logic [7:0]  mem_data_in,
  output logic        mem_we,
  input  logic [7:0]  mem_data_out
);

  // Elaboration-time parameter legality checks.
  if (READ_LAT < 1 || READ_LAT > 4) begin : g_bad_read_lat
    $error("dram_ctrl: READ_LAT must be in 1..4");
  end
  if (REFRESH_INTERVAL < 8) begin : g_bad_interval
    $error("dram_ctrl: REFRESH_INTERVAL must be at least 8");
  end
  if (ROW_BITS < 1 || ROW_BITS > 8) begin : g_bad_row_bits
    $error("dram_ctrl: ROW_BITS must be in 1..8");
  end

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ_ISSUE,
    READ_WAIT,
    REFRESH
  } state_e;

  // Last count value in READ_WAIT (READ_LAT cycles) and REFRESH (READ_LAT+1 cycles).
  localparam logic [2:0] WAIT_LAST = 3'(READ_LAT - 1);
  localparam logic [2:0] REF_LAST  = 3'(READ_LAT);

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [11:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [7:0]  rsp_rdata_q, rsp_rdata_d;
  logic        accept;

`ifdef DRAM_CTRL_REFRESH_EN
  localparam int unsigned TW = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(REFRESH_INTERVAL - 1);

  logic [TW-1:0]       timer_q, timer_d;
  logic                timer_wrap;
  logic                pending_q, pending_d;
  logic [ROW_BITS-1:0] row_q, row_d;
  logic                refresh_done;

  assign req_ready    = rst_n && (state_q == IDLE) && !pending_q;
  assign refresh_busy = (state_q == REFRESH);
`else
  assign req_ready    = rst_n && (state_q == IDLE);
  assign refresh_busy = 1'b0;
`endif

  assign accept      = req_valid && req_ready;
  assign mem_we      = (state_q == WRITE);
  assign mem_address = addr_q;
  assign mem_data_in = wdata_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;

  // Next-state and datapath decode for the request FSM.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
`ifdef DRAM_CTRL_REFRESH_EN
    refresh_done = 1'b0;
`endif
    case (state_q)
      IDLE: begin
`ifdef DRAM_CTRL_REFRESH_EN
        if (pending_q) begin
          state_d = REFRESH;
          cnt_d   = '0;
          addr_d  = 12'({row_q, 4'h0});
        end else
`endif
        if (accept) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          state_d = req_we ? WRITE : READ_ISSUE;
        end
      end
      WRITE: begin
        state_d = IDLE;
      end
      READ_ISSUE: begin
        cnt_d   = '0;
        state_d = READ_WAIT;
      end
      READ_WAIT: begin
        if (cnt_q == WAIT_LAST) begin
          rsp_rdata_d = mem_data_out;
          rsp_valid_d = 1'b1;
          state_d     = IDLE;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
`ifdef DRAM_CTRL_REFRESH_EN
      REFRESH: begin
        if (cnt_q == REF_LAST) begin
          refresh_done = 1'b1;
          state_d      = IDLE;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Request FSM state and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

`ifdef DRAM_CTRL_REFRESH_EN
  assign timer_wrap = (timer_q == TIMER_LAST);

  // Refresh timer, pending flag and row pointer next-state.
  always_comb begin
    timer_d   = timer_wrap ? '0 : timer_q + 1'b1;
    pending_d = pending_q;
    row_d     = row_q;
    // Completion clears pending; a wrap while already pending is dropped.
    if (refresh_done) begin
      pending_d = 1'b0;
      row_d     = row_q + 1'b1;
    end else if (timer_wrap) begin
      pending_d = 1'b1;
    end
  end

  // Refresh timer, pending flag and row pointer registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      timer_q   <= '0;
      pending_q <= 1'b0;
      row_q     <= '0;
    end else begin
      timer_q   <= timer_d;
      pending_q <= pending_d;
      row_q     <= row_d;
    end
  end
`endif

endmodule

// File: tb/tb_dram_ctrl.sv
// Self-checking bench for dram_ctrl with a behavioural synchronous array model.
// Refresh-specific sequences run only when DRAM_CTRL_REFRESH_EN is defined;
// the idle-stability sequence runs in the default build.
module tb_dram_ctrl;
  localparam int unsigned LAT      = 1;
  localparam int unsigned INTERVAL = 64;
  localparam int unsigned NV       = 11;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [11:0] req_addr;
  logic [7:0]  req_wdata;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        refresh_busy;
  logic [11:0] mem_address;
  logic [7:0]  mem_data_in;
  logic        mem_we;
  logic [7:0]  mem_data_out;

  int nvec = 0;
  int nerr = 0;

  dram_ctrl #(
    .READ_LAT(LAT),
    .REFRESH_INTERVAL(INTERVAL),
    .ROW_BITS(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we(req_we),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .refresh_busy(refresh_busy),
    .mem_address(mem_address),
    .mem_data_in(mem_data_in),
    .mem_we(mem_we),
    .mem_data_out(mem_data_out)
  );

  always #5 clk = ~clk;

  // Array model: write on mem_we, read data valid one cycle after the address.
  logic [7:0] mem [4096];
  logic [7:0] dout;
  initial for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
  always @(posedge clk) begin
    if (mem_we === 1'b1) mem[mem_address] <= mem_data_in;
    dout <= mem[mem_address];
  end
  assign mem_data_out = dout;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        we;
    logic [11:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  exp_rdata;
  } vec_t;
  vec_t vt [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Enters reset at a negedge, holds two rising edges, releases at a negedge.
  task automatic do_reset(input bit check_vals);
    rst_n     = 1'b0;
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    if (check_vals) begin
      chk("rst_req_ready", req_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_rdata", rsp_rdata, 0);
      chk("rst_refresh_busy", refresh_busy, 0);
      chk("rst_mem_address", mem_address, 0);
      chk("rst_mem_data_in", mem_data_in, 0);
      chk("rst_mem_we", mem_we, 0);
    end
    rst_n = 1'b1;
  endtask

  // Presents a request, waits (bounded) for acceptance; returns at negedge of cycle N+1.
  task automatic issue(input logic we, input logic [11:0] a, input logic [7:0] d);
    int n = 0;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    while (req_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      nvec++;
      nerr++;
      $display("FAIL accept_timeout: req_ready low for %0d cycles, want acceptance", n);
    end
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic check_write(input logic [11:0] a, input logic [7:0] d);
    chk("wr_mem_we", mem_we, 1);
    chk("wr_mem_address", mem_address, a);
    chk("wr_mem_data_in", mem_data_in, d);
    chk("wr_ready_low", req_ready, 0);
    chk("wr_no_rsp", rsp_valid, 0);
    @(negedge clk);
    chk("wr_we_drop", mem_we, 0);
    chk("wr_ready_back", req_ready, 1);
    chk("wr_addr_hold", mem_address, a);
    chk("wr_data_hold", mem_data_in, d);
    chk("wr_no_rsp2", rsp_valid, 0);
  endtask

  task automatic check_read(input logic [11:0] a, input logic [7:0] exp);
    chk("rd_mem_address", mem_address, a);
    chk("rd_mem_we", mem_we, 0);
    chk("rd_ready_low", req_ready, 0);
    chk("rd_no_rsp_issue", rsp_valid, 0);
    for (int i = 0; i < int'(LAT); i++) begin
      @(negedge clk);
      chk("rd_no_rsp_wait", rsp_valid, 0);
      chk("rd_addr_hold", mem_address, a);
    end
    @(negedge clk);
    chk("rd_rsp_valid", rsp_valid, 1);
    chk("rd_rsp_rdata", rsp_rdata, exp);
    chk("rd_ready_at_rsp", req_ready, 1);
    @(negedge clk);
    chk("rd_rsp_pulse", rsp_valid, 0);
    chk("rd_rdata_hold", rsp_rdata, exp);
  endtask

  initial begin
    int seen;
    int bad_busy, bad_addr, bad_ready;
    int n;
    logic [7:0] row;

    vt[0]  = '{1'b1, 12'h000, 8'hAA, 8'h00};
    vt[1]  = '{1'b0, 12'h000, 8'h00, 8'hAA};
    vt[2]  = '{1'b1, 12'hFFF, 8'h11, 8'h00};
    vt[3]  = '{1'b1, 12'h001, 8'h22, 8'h00};
    vt[4]  = '{1'b0, 12'hFFF, 8'h00, 8'h11};
    vt[5]  = '{1'b0, 12'h001, 8'h00, 8'h22};
    vt[6]  = '{1'b1, 12'h5A5, 8'h3C, 8'h00};
    vt[7]  = '{1'b0, 12'h5A5, 8'h00, 8'h3C};
    vt[8]  = '{1'b0, 12'h123, 8'h00, 8'h00};
    vt[9]  = '{1'b1, 12'h000, 8'hFF, 8'h00};
    vt[10] = '{1'b0, 12'h000, 8'h00, 8'hFF};

    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    do_reset(1'b1);

    // Table: each vector starts from reset so refresh timing cannot interfere.
    for (int i = 0; i < int'(NV); i++) begin
      do_reset(1'b0);
      issue(vt[i].we, vt[i].addr, vt[i].wdata);
      if (vt[i].we) check_write(vt[i].addr, vt[i].wdata);
      else          check_read(vt[i].addr, vt[i].exp_rdata);
    end

    // Back-to-back reads: second accepted in the response cycle of the first.
    do_reset(1'b0);
    issue(1'b0, 12'hFFF, 8'h00);
    repeat (LAT + 1) @(negedge clk);
    chk("b2b_rsp1_valid", rsp_valid, 1);
    chk("b2b_rsp1_rdata", rsp_rdata, 8'h11);
    chk("b2b_ready_at_rsp1", req_ready, 1);
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 12'h001;
    @(negedge clk);
    req_valid = 1'b0;
    chk("b2b_rsp1_pulse", rsp_valid, 0);
    chk("b2b_addr2", mem_address, 12'h001);
    chk("b2b_rdata_hold1", rsp_rdata, 8'h11);
    repeat (LAT + 1) @(negedge clk);
    chk("b2b_rsp2_valid", rsp_valid, 1);
    chk("b2b_rsp2_rdata", rsp_rdata, 8'h22);
    repeat (3) @(negedge clk);
    chk("b2b_rsp2_pulse", rsp_valid, 0);
    chk("b2b_rdata_hold2", rsp_rdata, 8'h22);

    // Reset in the cycle mem_we is high.
    issue(1'b1, 12'h0AB, 8'h77);
    chk("rstw_mem_we_before", mem_we, 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rstw_mem_we", mem_we, 0);
    chk("rstw_req_ready", req_ready, 0);
    chk("rstw_mem_address", mem_address, 0);
    chk("rstw_mem_data_in", mem_data_in, 0);
    chk("rstw_rsp_rdata", rsp_rdata, 0);
    chk("rstw_rsp_valid", rsp_valid, 0);
    chk("rstw_refresh_busy", refresh_busy, 0);
    rst_n = 1'b1;

    // Reset while a read sits in READ_WAIT: no response afterwards.
    issue(1'b0, 12'h000, 8'h00);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0) seen++;
    end
    chk("abort_no_rsp", seen, 0);
    chk("abort_rdata_reset", rsp_rdata, 0);

`ifdef DRAM_CTRL_REFRESH_EN
    // Refresh pending rises while a read is waiting to be presented.
    do_reset(1'b0);
    repeat (INTERVAL - 1) @(negedge clk);
    chk("ref_ready_before_wrap", req_ready, 1);
    @(negedge clk);
    chk("ref_ready_pending", req_ready, 0);
    chk("ref_busy_pending", refresh_busy, 0);
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 12'hFFF;
    for (int k = 0; k < int'(LAT) + 1; k++) begin
      @(negedge clk);
      chk("ref_busy", refresh_busy, 1);
      chk("ref_address", mem_address, 12'h000);
      chk("ref_mem_we", mem_we, 0);
      chk("ref_ready_busy", req_ready, 0);
    end
    @(negedge clk);
    chk("ref_busy_end", refresh_busy, 0);
    chk("ref_ready_after", req_ready, 1);
    @(negedge clk);
    req_valid = 1'b0;
    check_read(12'hFFF, 8'h11);

    // Row sweep across all 256 rows and the wrap back to row 0.
    do_reset(1'b0);
    for (int i = 0; i < 257; i++) begin
      row = 8'(i);
      n = 0;
      while (refresh_busy !== 1'b1 && n < int'(2 * INTERVAL)) begin
        @(negedge clk);
        n++;
      end
      chk("sweep_found", n < int'(2 * INTERVAL), 1);
      chk("sweep_address", mem_address, {row, 4'h0});
      n = 0;
      while (refresh_busy === 1'b1 && n < 10) begin
        @(negedge clk);
        n++;
      end
      if (i == 0) chk("sweep_busy_len", n, LAT + 1);
    end
`else
    // Default build: 1000 idle cycles with no refresh activity.
    do_reset(1'b0);
    bad_busy  = 0;
    bad_addr  = 0;
    bad_ready = 0;
    repeat (1000) begin
      @(negedge clk);
      if (refresh_busy !== 1'b0)       bad_busy++;
      if (mem_address !== 12'h000)     bad_addr++;
      if (req_ready !== 1'b1)          bad_ready++;
    end
    chk("idle_refresh_busy", bad_busy, 0);
    chk("idle_mem_address", bad_addr, 0);
    chk("idle_req_ready", bad_ready, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/dram_ctrl.md
# dram_ctrl

Request controller that sits directly upstream of the `dram` array model. It drives the array's `address`/`data_in`/`we` port and captures `data_out`. Host agents issue single-beat read/write requests over a valid/ready handshake and get read data back as a one-cycle response pulse. An optional refresh engine periodically steals the array port and sweeps rows in order.

## Interface
- `READ_LAT`, 1: cycles from address driven to `mem_data_out` valid; legal values 1–4.
- `REFRESH_INTERVAL`, 64: cycles between refresh requests; must be ≥ 8.
- `ROW_BITS`, 8: refresh row pointer width; refresh address is `{row, 4'h0}` (12 bits total).

Ports:
- `clk` in 1: single clock; all logic on the rising edge.
- `rst_n` in 1: synchronous active-low reset.
- `req_valid` in 1: host request valid.
- `req_ready` out 1: controller can accept a request.
- `req_we` in 1: 1 = write, 0 = read.
- `req_addr` in 12: request address.
- `req_wdata` in 8: write data.
- `rsp_valid` out 1: one-cycle pulse with read data.
- `rsp_rdata` out 8: read data; holds until the next read response.
- `refresh_busy` out 1: high while a refresh occupies the array.
- `mem_address` out 12: to `dram.address`.
- `mem_data_in` out 8: to `dram.data_in`.
- `mem_we` out 1: to `dram.we`.
- `mem_data_out` in 8: from `dram.data_out`.

## Operation
- FSM states: IDLE, WRITE, READ_ISSUE, READ_WAIT, REFRESH.
- `req_ready` = (state == IDLE) && !refresh_pending, decoded combinationally from state.
- A request is accepted on an edge where `req_valid && req_ready` is true. The controller latches `req_we`, `req_addr` and `req_wdata`.
- IDLE transitions:
  - refresh_pending → REFRESH. Refresh has priority over a simultaneous `req_valid`.
  - Accepted write → WRITE.
  - Accepted read → READ_ISSUE.
- WRITE: drive `mem_we`=1 with the latched address and data for exactly 1 cycle, then return to IDLE. No response is produced for writes.
- READ_ISSUE: drive the latched address with `mem_we`=0, then go to READ_WAIT.
- READ_WAIT: hold the address. After READ_LAT−1 cycles in this state, register `mem_data_out` into `rsp_rdata`, pulse `rsp_valid` on the next cycle, and return to IDLE in that same cycle.
- REFRESH:
  - Drive `mem_address`={row,4'h0} with `mem_we`=0 for READ_LAT+1 cycles; read data is discarded.
  - Then clear pending, increment row (wraps from 2^ROW_BITS−1 to 0), and return to IDLE.
  - `refresh_busy`=1 for exactly these cycles.
- Refresh counter:
  - Free-runs from 0 to REFRESH_INTERVAL−1 and wraps.
  - On wrap it sets refresh_pending.
  - A wrap while refresh_pending is already set does not queue a second refresh.
- `mem_address`/`mem_data_in` hold their last values in IDLE; `mem_we` is 0 in every state except WRITE.

## Timing
- Reset values:
  - `req_ready`=0 while `rst_n`=0.
  - `rsp_valid`=0, `rsp_rdata`=0, `refresh_busy`=0.
  - `mem_address`=0, `mem_data_in`=0, `mem_we`=0.
  - State = IDLE; refresh counter = 0; row = 0; refresh_pending = 0.
- Write accepted at edge N: `mem_we`=1 during cycle N+1; `req_ready` high again in cycle N+2.
- Read accepted at edge N: address driven from cycle N+1; `rsp_valid` high in cycle N+2+READ_LAT (N+3 for default). `req_ready` is high in the same cycle as `rsp_valid`, so a back-to-back read costs 2+READ_LAT cycles.
- Refresh at default READ_LAT: 2 cycles of array occupancy plus return to IDLE.
- Reset asserted mid-operation: at the next edge the FSM goes to IDLE, `mem_we` drops to 0, no `rsp_valid` is produced for the aborted read, and pending refresh is cleared.

## Configuration
- `DRAM_CTRL_REFRESH_EN` defined: refresh counter, row pointer, REFRESH state and `refresh_busy` are compiled in, as described above.
- Not defined: no refresh logic. `req_ready` = (state == IDLE), `refresh_busy` is tied to 0, and the REFRESH state is unreachable or absent.

## Test plan
- Reset, then write 8'hAA to 12'h000, then read 12'h000 → `mem_we` pulses for 1 cycle; `rsp_valid` pulses 3 cycles after read accept with `rsp_rdata`=8'hAA.
- Write 8'h11 to 12'hFFF, then write 8'h22 to 12'h001, then read both → responses 8'h11 and 8'h22 in order; `rsp_rdata` holds 8'h22 afterwards.
- Hold `req_valid` (read) in the cycle refresh_pending rises → `req_ready`=0; `refresh_busy`=1 for 2 cycles with `mem_address`=12'h000 and `mem_we`=0; the read is then accepted with unchanged latency.
- Run 256×REFRESH_INTERVAL idle cycles → refresh addresses step 12'h000, 12'h010, …, 12'hFF0, then wrap to 12'h000.
- Assert `rst_n`=0 in the cycle `mem_we`=1 → `mem_we`=0 at the next edge and all outputs hold reset values; no `rsp_valid` for a read aborted in READ_WAIT.
- Build without `DRAM_CTRL_REFRESH_EN`, idle 1000 cycles → `refresh_busy` is never 1, `mem_address` never changes, and `req_ready`=1 throughout.
